conv_loop_ctrl: RTL and testbench

Loop-nest scheduler for one convolution layer over the on-chip feature-map and weight memories. On `start_i` it walks every output pixel of every output map and, for each, every (input map, kernel row, kernel column) term. Each term is issued as one beat carrying the input-FM address, the weight address, the output-FM address and accumulate framing. It sits between the layer sequencer and the MAC datapath, replacing software-side index generation.

---
 rtl/conv_loop_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_conv_loop_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_ctrl.sv
// Convolution loop-nest scheduler: issues one (input, weight, output) address beat per MAC term.
// Optional performance counters are enabled with `define CONV_LOOP_CTRL_PERF_EN.
module conv_loop_ctrl #(
    parameter  int N_p  = 4,
    parameter  int M_p  = 4,
    parameter  int K_p  = 2,
    parameter  int R_p  = 16,
    parameter  int C_p  = 16,
    localparam int RO   = R_p - K_p + 1,
    localparam int CO   = C_p - K_p + 1,
    localparam int IA_N = N_p * R_p * C_p,
    localparam int WA_N = M_p * N_p * K_p * K_p,
    localparam int OA_N = M_p * RO * CO,
    localparam int IA_W = (IA_N > 1) ? $clog2(IA_N) : 1,
    localparam int WA_W = (WA_N > 1) ? $clog2(WA_N) : 1,
    localparam int OA_W = (OA_N > 1) ? $clog2(OA_N) : 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [IA_W-1:0] in_addr_o,
    output logic [WA_W-1:0] w_addr_o,
    output logic [OA_W-1:0] out_addr_o,
    output logic            acc_first_o,
    output logic            acc_last_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     run_cnt_o
);

    localparam int MW = (M_p > 1) ? $clog2(M_p) : 1;
    localparam int RW = (RO  > 1) ? $clog2(RO)  : 1;
    localparam int CW = (CO  > 1) ? $clog2(CO)  : 1;
    localparam int NW = (N_p > 1) ? $clog2(N_p) : 1;
    localparam int KW = (K_p > 1) ? $clog2(K_p) : 1;

    localparam logic [MW-1:0] M_MAX = MW'(M_p - 1);
    localparam logic [RW-1:0] R_MAX = RW'(RO - 1);
    localparam logic [CW-1:0] C_MAX = CW'(CO - 1);
    localparam logic [NW-1:0] N_MAX = NW'(N_p - 1);
    localparam logic [KW-1:0] K_MAX = KW'(K_p - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [MW-1:0] m, m_nxt;
    logic [RW-1:0] r, r_nxt;
    logic [CW-1:0] c, c_nxt;
    logic [NW-1:0] n, n_nxt;
    logic [KW-1:0] i, i_nxt;
    logic [KW-1:0] j, j_nxt;

    logic            launch, hs, all_last;
    logic            m_last, r_last, c_last, n_last, i_last, j_last;
    logic [IA_W-1:0] in_addr_d;
    logic [WA_W-1:0] w_addr_d;
    logic [OA_W-1:0] out_addr_d;
    logic            first_d, last_d;

    assign launch = (state == S_IDLE) && start_i;
    assign hs     = (state == S_RUN) && ready_i;

    assign m_last   = (m == M_MAX);
    assign r_last   = (r == R_MAX);
    assign c_last   = (c == C_MAX);
    assign n_last   = (n == N_MAX);
    assign i_last   = (i == K_MAX);
    assign j_last   = (j == K_MAX);
    assign all_last = m_last && r_last && c_last && n_last && i_last && j_last;

    // Odometer step: innermost non-saturated counter increments, everything inside it wraps.
    always_comb begin
        m_nxt = m;
        r_nxt = r;
        c_nxt = c;
        n_nxt = n;
        i_nxt = i;
        j_nxt = j;
        if (launch) begin
            m_nxt = '0;
            r_nxt = '0;
            c_nxt = '0;
            n_nxt = '0;
            i_nxt = '0;
            j_nxt = '0;
        end else if (!j_last) begin
            j_nxt = j + 1'b1;
        end else begin
            j_nxt = '0;
            if (!i_last) begin
                i_nxt = i + 1'b1;
            end else begin
                i_nxt = '0;
                if (!n_last) begin
                    n_nxt = n + 1'b1;
                end else begin
                    n_nxt = '0;
                    if (!c_last) begin
                        c_nxt = c + 1'b1;
                    end else begin
                        c_nxt = '0;
                        if (!r_last) begin
                            r_nxt = r + 1'b1;
                        end else begin
                            r_nxt = '0;
                            m_nxt = m_last ? '0 : m + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Addresses are precomputed from the next counter values so the outputs can be registered.
    always_comb begin
        in_addr_d  = IA_W'(32'(n_nxt) * 32'(R_p * C_p)
                         + (32'(r_nxt) + 32'(i_nxt)) * 32'(C_p)
                         + 32'(c_nxt) + 32'(j_nxt));
        w_addr_d   = WA_W'(((32'(m_nxt) * 32'(N_p) + 32'(n_nxt)) * 32'(K_p) + 32'(i_nxt))
                         * 32'(K_p) + 32'(j_nxt));
        out_addr_d = OA_W'(32'(m_nxt) * 32'(RO * CO) + 32'(r_nxt) * 32'(CO) + 32'(c_nxt));
        first_d    = (n_nxt == '0) && (i_nxt == '0) && (j_nxt == '0);
        last_d     = (n_nxt == N_MAX) && (i_nxt == K_MAX) && (j_nxt == K_MAX);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            m           <= '0;
            r           <= '0;
            c           <= '0;
            n           <= '0;
            i           <= '0;
            j           <= '0;
            in_addr_o   <= '0;
            w_addr_o    <= '0;
            out_addr_o  <= '0;
            acc_first_o <= 1'b0;
            acc_last_o  <= 1'b0;
        end else begin
            if (launch || hs) begin
                m <= m_nxt;
                r <= r_nxt;
                c <= c_nxt;
                n <= n_nxt;
                i <= i_nxt;
                j <= j_nxt;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state       <= S_RUN;
                        in_addr_o   <= in_addr_d;
                        w_addr_o    <= w_addr_d;
                        out_addr_o  <= out_addr_d;
                        acc_first_o <= first_d;
                        acc_last_o  <= last_d;
                    end
                end
                S_RUN: begin
                    if (ready_i) begin
                        if (all_last) begin
                            state       <= S_DONE;
                            in_addr_o   <= '0;
                            w_addr_o    <= '0;
                            out_addr_o  <= '0;
                            acc_first_o <= 1'b0;
                            acc_last_o  <= 1'b0;
                        end else begin
                            in_addr_o   <= in_addr_d;
                            w_addr_o    <= w_addr_d;
                            out_addr_o  <= out_addr_d;
                            acc_first_o <= first_d;
                            acc_last_o  <= last_d;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = (state == S_RUN);
    assign valid_o = (state == S_RUN);
    assign done_o  = (state == S_DONE);

`ifdef CONV_LOOP_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] run_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
        end else if (launch) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
        end else if (state == S_RUN) begin
            run_cnt <= sat_inc(run_cnt);
            if (!ready_i) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign run_cnt_o   = run_cnt;
`else
    assign stall_cnt_o = '0;
    assign run_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Directed bench for conv_loop_ctrl: default layer, backpressure, mid-run start/reset, K=1 layer.
module tb_conv_loop_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic        busy, done, valid, af, al;
    logic [9:0]  ia;
    logic [5:0]  wa;
    logic [9:0]  oa;
    logic [31:0] scnt, rcnt;

    logic        s_rst, s_start, s_ready;
    logic        s_busy, s_done, s_valid, s_af, s_al;
    logic [3:0]  s_ia;
    logic [0:0]  s_wa;
    logic [4:0]  s_oa;
    logic [31:0] s_scnt, s_rcnt;

    int total = 0;
    int bad   = 0;
    int k, cyc, ndone, dcyc, stalls, runs, sk, sdone;

    always #5 clk = ~clk;

    conv_loop_ctrl u_dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .valid_o(valid), .ready_i(ready), .in_addr_o(ia), .w_addr_o(wa), .out_addr_o(oa),
        .acc_first_o(af), .acc_last_o(al), .stall_cnt_o(scnt), .run_cnt_o(rcnt)
    );

    conv_loop_ctrl #(.N_p(1), .M_p(2), .K_p(1), .R_p(3), .C_p(3)) u_small (
        .clk_i(clk), .reset_i(s_rst), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
        .valid_o(s_valid), .ready_i(s_ready), .in_addr_o(s_ia), .w_addr_o(s_wa),
        .out_addr_o(s_oa), .acc_first_o(s_af), .acc_last_o(s_al),
        .stall_cnt_o(s_scnt), .run_cnt_o(s_rcnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference beat decode: beat index -> (m,r,c,n,i,j) -> addresses and framing.
    function automatic void model(input int kk, input int nn, input int mm, input int kz,
                                  input int rr, input int cc, output int ei, output int ew,
                                  output int eo, output bit ef, output bit el);
        int ro, co, bj, bi, bn, bc, br, bm, q;
        ro = rr - kz + 1;
        co = cc - kz + 1;
        q  = kk;
        bj = q % kz; q = q / kz;
        bi = q % kz; q = q / kz;
        bn = q % nn; q = q / nn;
        bc = q % co; q = q / co;
        br = q % ro; q = q / ro;
        bm = q;
        ei = bn * rr * cc + (br + bi) * cc + bc + bj;
        ew = ((bm * nn + bn) * kz + bi) * kz + bj;
        eo = bm * ro * co + br * co + bc;
        ef = (bn == 0) && (bi == 0) && (bj == 0);
        el = (bn == nn - 1) && (bi == kz - 1) && (bj == kz - 1);
        if (mm < 1) ef = 1'b0;
    endfunction

    task automatic chk_beat(input string tag, input int kk);
        int ei, ew, eo;
        bit ef, el;
        model(kk, 4, 4, 2, 16, 16, ei, ew, eo, ef, el);
        chk({tag, "_in"}, 64'(ia), 64'(ei));
        chk({tag, "_w"}, 64'(wa), 64'(ew));
        chk({tag, "_out"}, 64'(oa), 64'(eo));
        chk({tag, "_first"}, 64'(af), 64'(ef));
        chk({tag, "_last"}, 64'(al), 64'(el));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_ready = 1'b0;
        step(); step();

        // Reset state
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in", 64'(ia), 64'd0);
        chk("rst_w", 64'(wa), 64'd0);
        chk("rst_out", 64'(oa), 64'd0);
        chk("rst_first", 64'(af), 64'd0);
        chk("rst_last", 64'(al), 64'd0);
        chk("rst_scnt", 64'(scnt), 64'd0);
        chk("rst_rcnt", 64'(rcnt), 64'd0);
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        rst = 1'b0; s_rst = 1'b0;
        step();

        // A: full default layer with ready held high
        ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        cyc = 1; k = 0; ndone = 0; dcyc = 0;
        chk("a_busy_t1", 64'(busy), 64'd1);
        chk("a_valid_t1", 64'(valid), 64'd1);
        while (cyc < 14410) begin
            if (valid) begin
                chk_beat("a", k);
                case (k)
                    0: begin
                        chk("a_b0_in", 64'(ia), 64'd0);
                        chk("a_b0_first", 64'(af), 64'd1);
                    end
                    1: begin
                        chk("a_b1_in", 64'(ia), 64'd1);
                        chk("a_b1_w", 64'(wa), 64'd1);
                    end
                    4: begin
                        chk("a_b4_in", 64'(ia), 64'd256);
                        chk("a_b4_w", 64'(wa), 64'd4);
                    end
                    15: chk("a_b15_last", 64'(al), 64'd1);
                    16: begin
                        chk("a_b16_out", 64'(oa), 64'd1);
                        chk("a_b16_first", 64'(af), 64'd1);
                    end
                    14399: begin
                        chk("a_bl_in", 64'(ia), 64'd1023);
                        chk("a_bl_w", 64'(wa), 64'd63);
                        chk("a_bl_out", 64'(oa), 64'd899);
                        chk("a_bl_last", 64'(al), 64'd1);
                    end
                    default: ;
                endcase
`ifndef CONV_LOOP_CTRL_PERF_EN
                chk("a_scnt_zero", 64'(scnt), 64'd0);
                chk("a_rcnt_zero", 64'(rcnt), 64'd0);
`endif
                k++;
            end
            if (done) begin
                ndone++;
                dcyc = cyc;
            end
            if (cyc == 14402) chk("a_idle_busy", 64'(busy), 64'd0);
            step();
            cyc++;
        end
        chk("a_beats", 64'(k), 64'd14400);
        chk("a_done_cnt", 64'(ndone), 64'd1);
        chk("a_done_cyc", 64'(dcyc), 64'd14401);
`ifdef CONV_LOOP_CTRL_PERF_EN
        chk("a_rcnt", 64'(rcnt), 64'd14400);
        chk("a_scnt", 64'(scnt), 64'd0);
`else
        chk("a_rcnt_end", 64'(rcnt), 64'd0);
        chk("a_scnt_end", 64'(scnt), 64'd0);
`endif

        // B: random backpressure, stray start pulse at beat 100
        start = 1'b1; step(); start = 1'b0;
        cyc = 0; k = 0; stalls = 0; runs = 0; ndone = 0;
        while (cyc < 40000 && ndone == 0) begin
            ready = 1'($urandom_range(0, 1));
            start = valid && (k == 100);
            if (valid) begin
                chk_beat("b", k);
                runs++;
                if (ready) k++;
                else stalls++;
            end
            if (done) ndone++;
            else step();
            cyc++;
        end
        chk("b_beats", 64'(k), 64'd14400);
        chk("b_done_cnt", 64'(ndone), 64'd1);
`ifdef CONV_LOOP_CTRL_PERF_EN
        chk("b_scnt", 64'(scnt), 64'(stalls));
        chk("b_rcnt", 64'(rcnt), 64'(runs));
`else
        chk("b_scnt", 64'(scnt), 64'd0);
        chk("b_rcnt", 64'(rcnt), 64'd0);
`endif
        // start coincident with done must be dropped
        start = 1'b1; step(); start = 1'b0;
        chk("b_coinc_busy0", 64'(busy), 64'd0);
        step();
        chk("b_coinc_busy1", 64'(busy), 64'd0);

        // C: reset at beat 5000, then a fresh start
        ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        k = 0;
        for (int t = 0; t < 6000 && k < 5000; t++) begin
            if (valid) begin
                chk_beat("c", k);
                k++;
            end
            step();
        end
        chk("c_reach", 64'(k), 64'd5000);
        chk_beat("c_b5000", 5000);
        rst = 1'b1;
        #1;
        chk("c_valid", 64'(valid), 64'd0);
        chk("c_busy", 64'(busy), 64'd0);
        chk("c_done", 64'(done), 64'd0);
        chk("c_in", 64'(ia), 64'd0);
        chk("c_w", 64'(wa), 64'd0);
        chk("c_out", 64'(oa), 64'd0);
        chk("c_flags", 64'({af, al}), 64'd0);
        chk("c_cnts", 64'(scnt | rcnt), 64'd0);
        step();
        chk("c_done_hold", 64'(done), 64'd0);
        rst = 1'b0;
        step();
        chk("c_done_after", 64'(done), 64'd0);
        chk("c_idle", 64'(busy), 64'd0);
        start = 1'b1; step(); start = 1'b0;
        for (int t = 0; t < 6; t++) begin
            chk("c_re_valid", 64'(valid), 64'd1);
            chk_beat("c_re", t);
            step();
        end

        // D: N=1, M=2, K=1, 3x3 layer
        s_ready = 1'b1;
        s_start = 1'b1; step(); s_start = 1'b0;
        sk = 0; sdone = 0;
        for (int t = 0; t < 40; t++) begin
            if (s_valid) begin
                chk("d_first", 64'(s_af), 64'd1);
                chk("d_last", 64'(s_al), 64'd1);
                chk("d_out", 64'(s_oa), 64'(sk));
                chk("d_in", 64'(s_ia), 64'(sk % 9));
                chk("d_w", 64'(s_wa), 64'(sk / 9));
                if (sk < 9) chk("d_in_eq_out", 64'(s_ia), 64'(s_oa));
                sk++;
            end
            if (s_done) sdone++;
            step();
        end
        chk("d_beats", 64'(sk), 64'd18);
        chk("d_done_cnt", 64'(sdone), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
